// File: rtl/pid_spd_mix.sv
// Heading PID output stage: sums P/I/D into a steering correction, soft-ramps the
// forward-speed base and mixes both into saturated left/right motor commands.
module pid_spd_mix #(
    parameter logic [10:0] FRWRD_MAX = 11'd672,
    parameter logic [10:0] RAMP_STEP = 11'd32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hdng_vld,
    input  logic               moving,
    input  logic signed [13:0] P_term,
    input  logic signed [11:0] I_term,
    input  logic signed [12:0] D_term,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               spd_vld,
    output logic               at_speed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic        [10:0] frwrd;
    logic        [10:0] frwrd_nxt;
    logic               at_speed_nxt;
    logic        [11:0] ramp_sum;
    logic        [11:0] decel_step;
    logic signed [14:0] sum_d;
    logic signed [14:0] sum_q;
    logic               v1;
    logic signed [15:0] base;
    logic signed [15:0] sum_ext;
    logic signed [15:0] lft_raw;
    logic signed [15:0] rght_raw;

    function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
        if (v > 16'sd2047) begin
            return 12'sd2047;
        end else if (v < -16'sd2048) begin
            return -12'sd2048;
        end else begin
            return v[11:0];
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loss of the move command outranks reaching the ceiling.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (moving) state_nxt = RAMP;
            end
            RAMP: begin
                if (!moving) begin
                    state_nxt = DECEL;
                end else if (frwrd == FRWRD_MAX) begin
                    state_nxt = CRUISE;
                end
            end
            CRUISE: begin
                if (!moving) state_nxt = DECEL;
            end
            DECEL: begin
                if (moving) begin
                    state_nxt = RAMP;
                end else if (frwrd == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ramp_sum   = {1'b0, frwrd} + {1'b0, RAMP_STEP};
        decel_step = {RAMP_STEP, 1'b0};
        frwrd_nxt  = frwrd;
        if (hdng_vld) begin
            case (state)
                RAMP: begin
                    frwrd_nxt = (ramp_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : ramp_sum[10:0];
                end
                DECEL: begin
                    frwrd_nxt = ({1'b0, frwrd} < decel_step) ? '0 : frwrd - decel_step[10:0];
                end
                default: frwrd_nxt = frwrd;
            endcase
        end
        at_speed_nxt = (state_nxt == CRUISE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frwrd    <= '0;
            at_speed <= 1'b0;
        end else begin
            frwrd    <= frwrd_nxt;
            at_speed <= at_speed_nxt;
        end
    end

    // 15 bits hold the worst-case magnitude of the three terms without overflow.
    always_comb begin
        sum_d = $signed({P_term[13], P_term})
              + $signed({{3{I_term[11]}}, I_term})
              + $signed({{2{D_term[12]}}, D_term});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= hdng_vld;
            if (hdng_vld) begin
                sum_q <= sum_d;
            end
        end
    end

    always_comb begin
        base     = $signed({5'b0, frwrd});
        sum_ext  = $signed({sum_q[14], sum_q});
        lft_raw  = base + sum_ext;
        rght_raw = base - sum_ext;
    end

    // frwrd here already carries the update from the strobe that loaded sum_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= v1;
            if (v1) begin
                if (state == IDLE) begin
                    lft_spd  <= '0;
                    rght_spd <= '0;
                end else begin
                    lft_spd  <= sat12(lft_raw);
                    rght_spd <= sat12(rght_raw);
                end
            end
        end
    end

endmodule

// File: tb/tb_pid_spd_mix.sv
// Self-checking bench for pid_spd_mix: directed vector table and sequences, then
// randomized traffic against a cycle-level behavioural model.
module tb_pid_spd_mix;

    localparam int FMAX = 672;
    localparam int STEP = 32;

    localparam int M_IDLE   = 0;
    localparam int M_RAMP   = 1;
    localparam int M_CRUISE = 2;
    localparam int M_DECEL  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               hdng_vld;
    logic               moving;
    logic signed [13:0] p_term;
    logic signed [11:0] i_term;
    logic signed [12:0] d_term;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;
    logic               at_speed;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_mode, m_f, m_sum, m_v1, m_l, m_r, m_vld, m_at;

    typedef struct {
        int p;
        int i;
        int d;
        int lft;
        int rght;
    } mix_vec_t;

    mix_vec_t vecs[8];

    always #5 clk = ~clk;

    pid_spd_mix #(
        .FRWRD_MAX(11'd672),
        .RAMP_STEP(11'd32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hdng_vld(hdng_vld),
        .moving  (moving),
        .P_term  (p_term),
        .I_term  (i_term),
        .D_term  (d_term),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .spd_vld (spd_vld),
        .at_speed(at_speed)
    );

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_f    = 0;
        m_sum  = 0;
        m_v1   = 0;
        m_l    = 0;
        m_r    = 0;
        m_vld  = 0;
        m_at   = 0;
    endfunction

    function automatic void model_step();
        int nf;
        int nm;
        if (m_v1 != 0) begin
            m_vld = 1;
            if (m_mode == M_IDLE) begin
                m_l = 0;
                m_r = 0;
            end else begin
                m_l = clamp(m_f + m_sum);
                m_r = clamp(m_f - m_sum);
            end
        end else begin
            m_vld = 0;
        end
        m_v1 = int'(hdng_vld);
        if (hdng_vld) m_sum = int'(p_term) + int'(i_term) + int'(d_term);
        nf = m_f;
        if (hdng_vld && m_mode == M_RAMP)  nf = (m_f + STEP > FMAX) ? FMAX : m_f + STEP;
        if (hdng_vld && m_mode == M_DECEL) nf = (m_f - 2 * STEP < 0) ? 0 : m_f - 2 * STEP;
        nm = m_mode;
        case (m_mode)
            M_IDLE:   if (moving) nm = M_RAMP;
            M_RAMP:   nm = !moving ? M_DECEL : (m_f == FMAX ? M_CRUISE : M_RAMP);
            M_CRUISE: if (!moving) nm = M_DECEL;
            default:  nm = moving ? M_RAMP : (m_f == 0 ? M_IDLE : M_DECEL);
        endcase
        m_f    = nf;
        m_mode = nm;
        m_at   = (nm == M_CRUISE) ? 1 : 0;
    endfunction

    task automatic tick();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_terms(input int p, input int i, input int d);
        p_term = 14'(p);
        i_term = 12'(i);
        d_term = 13'(d);
    endtask

    // One strobe followed by one idle cycle: the result is visible on return.
    task automatic pulse(input int p, input int i, input int d);
        set_terms(p, i, d);
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{p: 100,   i: -20,   d: -30,   lft: 722,   rght: 622};
        vecs[1] = '{p: 8191,  i: 2047,  d: 4095,  lft: 2047,  rght: -2048};
        vecs[2] = '{p: -8191, i: -2047, d: -4095, lft: -2048, rght: 2047};
        vecs[3] = '{p: 0,     i: 0,     d: 0,     lft: 672,   rght: 672};
        vecs[4] = '{p: -8192, i: -2048, d: -4096, lft: -2048, rght: 2047};
        vecs[5] = '{p: 1375,  i: 0,     d: 0,     lft: 2047,  rght: -703};
        vecs[6] = '{p: 1000,  i: 376,   d: 0,     lft: 2047,  rght: -704};
        vecs[7] = '{p: -2720, i: 0,     d: 0,     lft: -2048, rght: 2047};

        rst      = 1'b1;
        moving   = 1'b0;
        hdng_vld = 1'b0;
        set_terms(0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        tick();
        check("reset_lft", int'(lft_spd), 0);
        check("reset_rght", int'(rght_spd), 0);
        check("reset_vld", int'(spd_vld), 0);
        check("reset_at_speed", int'(at_speed), 0);
        rst = 1'b0;

        // Ramp-up to the ceiling
        moving = 1'b1;
        tick();
        for (int k = 1; k <= 21; k++) begin
            set_terms(0, 0, 0);
            hdng_vld = 1'b1;
            tick();
            check("ramp_vld_early", int'(spd_vld), 0);
            check("ramp_at_speed_early", int'(at_speed), 0);
            hdng_vld = 1'b0;
            tick();
            check("ramp_vld", int'(spd_vld), 1);
            check("ramp_lft", int'(lft_spd), STEP * k);
            check("ramp_at_speed", int'(at_speed), (k == 21) ? 1 : 0);
        end
        pulse(0, 0, 0);
        check("ramp_hold_lft", int'(lft_spd), FMAX);
        check("ramp_hold_at_speed", int'(at_speed), 1);

        // Mix, latency and saturation vectors at cruise speed
        foreach (vecs[n]) begin
            set_terms(vecs[n].p, vecs[n].i, vecs[n].d);
            hdng_vld = 1'b1;
            tick();
            check("mix_vld_n1", int'(spd_vld), 0);
            hdng_vld = 1'b0;
            tick();
            check("mix_vld_n2", int'(spd_vld), 1);
            check("mix_lft", int'(lft_spd), vecs[n].lft);
            check("mix_rght", int'(rght_spd), vecs[n].rght);
            tick();
            check("mix_vld_n3", int'(spd_vld), 0);
        end

        // Asynchronous reset with a result in flight
        set_terms(50, 0, 0);
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_lft", int'(lft_spd), 0);
        check("async_rst_rght", int'(rght_spd), 0);
        check("async_rst_at_speed", int'(at_speed), 0);
        tick();
        moving = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_pipe_discard", int'(spd_vld), 0);
        pulse(100, 0, 0);
        check("rst_idle_vld", int'(spd_vld), 1);
        check("rst_idle_lft", int'(lft_spd), 0);
        check("rst_idle_rght", int'(rght_spd), 0);

        // Deceleration from cruise back to idle
        moving = 1'b1;
        tick();
        repeat (21) pulse(0, 0, 0);
        check("recruise_at_speed", int'(at_speed), 1);
        moving = 1'b0;
        tick();
        check("decel_at_speed", int'(at_speed), 0);
        for (int k = 1; k <= 11; k++) begin
            pulse(0, 0, 0);
            check("decel_lft", int'(lft_spd), (FMAX - 2 * STEP * k < 0) ? 0 : FMAX - 2 * STEP * k);
            check("decel_rght", int'(rght_spd), (FMAX - 2 * STEP * k < 0) ? 0 : FMAX - 2 * STEP * k);
        end
        pulse(100, 0, 0);
        check("idle_force_vld", int'(spd_vld), 1);
        check("idle_force_lft", int'(lft_spd), 0);
        check("idle_force_rght", int'(rght_spd), 0);

        // Reversal mid-ramp
        moving = 1'b1;
        tick();
        repeat (10) pulse(0, 0, 0);
        check("rev_peak", int'(lft_spd), 320);
        moving = 1'b0;
        tick();
        pulse(0, 0, 0);
        check("rev_dec1", int'(lft_spd), 256);
        pulse(0, 0, 0);
        check("rev_dec2", int'(lft_spd), 192);
        moving = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            pulse(0, 0, 0);
            check("rev_ramp", int'(lft_spd), 192 + STEP * k);
        end

        // Randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        moving = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int sel;
            if ($urandom_range(99) == 0) moving = ~moving;
            hdng_vld = 1'($urandom_range(1));
            sel = int'($urandom_range(7));
            if (sel == 0) set_terms(8191, 2047, 4095);
            else if (sel == 1) set_terms(-8192, -2048, -4096);
            else begin
                p_term = 14'($urandom);
                i_term = 12'($urandom);
                d_term = 13'($urandom);
            end
            tick();
            check("rnd_lft", int'(lft_spd), m_l);
            check("rnd_rght", int'(rght_spd), m_r);
            check("rnd_vld", int'(spd_vld), m_vld);
            check("rnd_at_speed", int'(at_speed), m_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
